// File: rtl/hazard_pkg.sv
// hazard_pkg: shared register-tag types and constants for the hazard subsystem.
package hazard_pkg;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = '0;
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
  } tag_entry_t;
  localparam tag_entry_t TAG_BUBBLE = '{valid: 1'b0, rd: REG_X0, we: 1'b0, is_load: 1'b0};
endpackage

// File: rtl/tag_stage.sv
// tag_stage: one pipeline tag slot; hold freezes it, bubble loads an empty entry.
module tag_stage import hazard_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       bubble,
  input  tag_entry_t d_in,
  output tag_entry_t q
);
  tag_entry_t entry_d, entry_q;
  always_comb entry_d = hold ? entry_q : bubble ? TAG_BUBBLE : d_in;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry_q <= TAG_BUBBLE;
    else        entry_q <= entry_d;
  end
  assign q = entry_q;
endmodule

// File: rtl/dest_tag_tracker.sv
// dest_tag_tracker: EX/MEM/WB destination tags for forwarding plus load-use stall detect.
// Optional load-use stall counter enabled by defining HAZ_PERF_CNT_EN.
module dest_tag_tracker import hazard_pkg::*; #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_uses_rb,
  input  logic              stall_in,
  input  logic              flush_ex,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_we,
  output logic [REG_AW-1:0] rd_mem,
  output logic              we_mem,
  output logic [REG_AW-1:0] rd_wb,
  output logic              we_wb,
  output logic              load_use_stall
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt
`endif
);
  tag_entry_t id_entry, ex_q, mem_q, wb_q;
  logic       unused_wb_load;
  assign id_entry = '{valid: id_valid, rd: id_rd, we: id_we & (id_rd != REG_X0), is_load: id_is_load};
  assign load_use_stall = ex_q.valid & ex_q.we & ex_q.is_load & id_valid & ~flush_ex &
                          ((ex_q.rd == id_ra) | (id_uses_rb & (ex_q.rd == id_rb)));
  tag_stage u_ex (
    .clk(clk), .rst_n(rst_n), .hold(stall_in), .bubble(flush_ex | load_use_stall),
    .d_in(id_entry), .q(ex_q)
  );
  tag_stage u_mem (
    .clk(clk), .rst_n(rst_n), .hold(stall_in), .bubble(1'b0), .d_in(ex_q), .q(mem_q)
  );
  tag_stage u_wb (
    .clk(clk), .rst_n(rst_n), .hold(stall_in), .bubble(1'b0), .d_in(mem_q), .q(wb_q)
  );
  // Load data is not available until WB, so a load in MEM never forwards.
  assign ex_rd  = ex_q.valid ? ex_q.rd : REG_X0;
  assign ex_we  = ex_q.valid & ex_q.we;
  assign rd_mem = mem_q.valid ? mem_q.rd : REG_X0;
  assign we_mem = mem_q.valid & mem_q.we & ~mem_q.is_load;
  assign rd_wb  = wb_q.valid ? wb_q.rd : REG_X0;
  assign we_wb  = wb_q.valid & wb_q.we;
  assign unused_wb_load = wb_q.is_load;
`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q;
  always_comb stall_cnt_d = (load_use_stall & ~stall_in & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`else
  logic [PERF_W-1:0] unused_perf;
  assign unused_perf = '0;
`endif
endmodule

// File: tb/tb_dest_tag_tracker.sv
// tb_dest_tag_tracker: scoreboard bench for dest_tag_tracker (define HAZ_PERF_CNT_EN to also check stall_cnt).
module tb_dest_tag_tracker;
  logic       clk = 0, rst_n = 0;
  logic       id_valid = 0, id_we = 0, id_is_load = 0, id_uses_rb = 0, stall_in = 0, flush_ex = 0;
  logic [4:0] id_rd = 0, id_ra = 0, id_rb = 0;
  logic [4:0] ex_rd, rd_mem, rd_wb;
  logic       ex_we, we_mem, we_wb, load_use_stall;
  logic [31:0] stall_cnt;
  int checks = 0, errors = 0;
  typedef struct {bit v; bit [4:0] r; bit w; bit l;} ent_t;
  typedef struct {logic [4:0] exr; logic exw; logic [4:0] mr; logic mw; logic [4:0] wr; logic ww; logic [31:0] cnt;} exp_t;
  ent_t m[3];
  exp_t sb[$];
  logic [31:0] m_cnt = 0;
  always #5 clk = ~clk;
  dest_tag_tracker dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_ra(id_ra), .id_rb(id_rb), .id_uses_rb(id_uses_rb),
    .stall_in(stall_in), .flush_ex(flush_ex), .ex_rd(ex_rd), .ex_we(ex_we),
    .rd_mem(rd_mem), .we_mem(we_mem), .rd_wb(rd_wb), .we_wb(we_wb),
    .load_use_stall(load_use_stall)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
`ifndef HAZ_PERF_CNT_EN
  assign stall_cnt = '0;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input bit v, input bit [4:0] rd, input bit we, input bit ld,
                       input bit [4:0] ra, input bit [4:0] rb, input bit urb, input bit st, input bit fl);
    id_valid = v; id_rd = rd; id_we = we; id_is_load = ld; id_ra = ra; id_rb = rb;
    id_uses_rb = urb; stall_in = st; flush_ex = fl;
  endtask
  task automatic clear_model();
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0};
    m_cnt = 0;
  endtask
  task automatic tick();
    bit lu;
    exp_t e, g;
    #1;
    lu = m[0].v && m[0].w && m[0].l && id_valid && !flush_ex &&
         (m[0].r == id_ra || (id_uses_rb && m[0].r == id_rb));
    check("lu", load_use_stall, lu);
    if (!stall_in) begin
      if (lu && m_cnt != 32'hffff_ffff) m_cnt++;
      m[2] = m[1];
      m[1] = m[0];
      m[0] = (flush_ex || lu) ? '{0, 0, 0, 0} : '{id_valid, id_rd, id_we && id_rd != 0, id_is_load};
    end
    e.exr = m[0].v ? m[0].r : 0; e.exw = m[0].v & m[0].w;
    e.mr  = m[1].v ? m[1].r : 0; e.mw  = m[1].v & m[1].w & ~m[1].l;
    e.wr  = m[2].v ? m[2].r : 0; e.ww  = m[2].v & m[2].w;
`ifdef HAZ_PERF_CNT_EN
    e.cnt = m_cnt;
`else
    e.cnt = 0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("ex_rd", ex_rd, g.exr);   check("ex_we", ex_we, g.exw);
    check("rd_mem", rd_mem, g.mr);  check("we_mem", we_mem, g.mw);
    check("rd_wb", rd_wb, g.wr);    check("we_wb", we_wb, g.ww);
    check("stall_cnt", stall_cnt, g.cnt);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ex"}, {ex_rd, ex_we}, 0);
    check({tag, "_mem"}, {rd_mem, we_mem}, 0);
    check({tag, "_wb"}, {rd_wb, we_wb}, 0);
    check({tag, "_lu"}, load_use_stall, 0);
    check({tag, "_cnt"}, stall_cnt, 0);
  endtask
  initial begin
    clear_model();
    #3 check_zero("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    // ALU op to x5 walks through EX, MEM, WB
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0); tick();
    check("alu_ex", ex_rd, 5);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("alu_mem", {rd_mem, we_mem}, {5'd5, 1'b1});
    tick();
    check("alu_wb", {rd_wb, we_wb}, {5'd5, 1'b1});
    // load to x7 followed by consumer on ra
    drive(1, 7, 1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 8, 1, 0, 7, 1, 1, 0, 0); #1 check("lu_ra", load_use_stall, 1);
    tick();
    check("lu_bubble", {ex_rd, ex_we}, 0);
    check("lu_mem_gated", {rd_mem, we_mem}, {5'd7, 1'b0});
    tick();
    check("lu_wb", {rd_wb, we_wb}, {5'd7, 1'b1});
`ifdef HAZ_PERF_CNT_EN
    check("cnt_one", stall_cnt, 1);
`endif
    // rb match ignored when rb is an immediate
    drive(1, 7, 1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 9, 1, 0, 3, 7, 0, 0, 0); #1 check("lu_imm", load_use_stall, 0);
    tick();
    drive(1, 7, 1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 9, 1, 0, 3, 7, 1, 0, 0); #1 check("lu_rb", load_use_stall, 1);
    tick(); tick();
    // x0 destination never forwards
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    check("x0_ex", ex_we, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("x0_mem", we_mem, 0);
    tick();
    check("x0_wb", we_wb, 0);
    // external stall freezes everything for three cycles
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 10, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    check("stall_hold", ex_rd, 9);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("stall_resume", rd_mem, 9);
    // stall_in and load-use together: nothing moves, counter unchanged
    drive(1, 7, 1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 4, 1, 0, 7, 0, 0, 1, 0); tick();
    check("stall_lu_hold", ex_rd, 7);
    // flush beats load-use
    drive(1, 4, 1, 0, 7, 0, 0, 0, 1); #1 check("flush_lu", load_use_stall, 0);
    tick();
    check("flush_bubble", {ex_rd, ex_we}, 0);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      tick();
    end
    // async reset mid-cycle with all slots valid
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 2, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0); tick();
    check("full_wb", rd_wb, 1);
    #2 rst_n = 0;
    #1 check_zero("async_rst");
    #1 rst_n = 1;
    clear_model();
    drive(1, 6, 1, 0, 0, 0, 0, 0, 0); tick();
    check("post_rst_mem", {rd_mem, we_mem}, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dest_tag_tracker.md
# dest_tag_tracker

Tracks the destination-register tags of in-flight instructions through the EX, MEM and WB stages. It is the producer side of the operand-forwarding interface: it generates the `rd_mem`/`we_mem`/`rd_wb`/`we_wb` tags that the forwarding selector compares against source registers. It also detects load-use hazards against the instruction in decode and requests a one-cycle stall. It sits in the hazard subsystem, between decode control and the forwarding unit.

## Interface
- `REG_AW`, 5: register index width.
- `PERF_W`, 32: stall-counter width; used only with `HAZ_PERF_CNT_EN`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: the decode-stage instruction is real and advances to EX this cycle.
- `id_rd` in REG_AW: destination register of the decode instruction.
- `id_we` in 1: the decode instruction writes the register file.
- `id_is_load` in 1: the decode instruction is a load.
- `id_ra` in REG_AW: source A of the decode instruction.
- `id_rb` in REG_AW: source B of the decode instruction.
- `id_uses_rb` in 1: source B is a register operand (0 when an immediate is selected).
- `stall_in` in 1: external freeze, e.g. memory wait.
- `flush_ex` in 1: kill the entry entering EX (branch redirect).
- `ex_rd` out REG_AW, `ex_we` out 1: EX-stage tag.
- `rd_mem` out REG_AW, `we_mem` out 1: MEM-stage tag, to the forwarding unit.
- `rd_wb` out REG_AW, `we_wb` out 1: WB-stage tag, to the forwarding unit.
- `load_use_stall` out 1: hold IF/ID and insert a bubble into EX.
- `stall_cnt` out PERF_W: load-use stall cycle count (only with `HAZ_PERF_CNT_EN`).

## Operation
- Three stage slots: EX, MEM, WB. Each slot holds `{valid, rd, we, is_load}`.
- Capture into EX: `we` is forced to 0 when `id_rd == 0`, so x0 is never forwarded.
- Exported write enable per slot = `valid & we`. For the MEM slot it is additionally gated with `~is_load`, because load data is not yet available in MEM.
- Load-use detection (combinational): `load_use_stall = EX.valid & EX.we & EX.is_load & (EX.rd == id_ra | (id_uses_rb & EX.rd == id_rb)) & id_valid & ~flush_ex`.
- Per-edge update, in priority order:
  - `stall_in = 1`: all slots hold.
  - `flush_ex = 1`: EX takes a bubble (`valid = 0`); MEM takes the old EX, WB takes the old MEM.
  - `load_use_stall = 1`: EX takes a bubble; MEM and WB advance normally.
  - Otherwise: EX takes the decode fields, with `valid = id_valid`; MEM takes the old EX; WB takes the old MEM.
- A bubble slot exports `we = 0` and `rd = 0`.
- A single load-use stall is always sufficient. The load reaches WB when the consumer reaches EX, and the forwarding unit then selects the WB path.

## Timing
- Reset, asynchronous while `rst_n = 0`: all slots are invalid with `rd = 0`, `we = 0`, `is_load = 0`. All tag outputs are 0, `load_use_stall = 0` and `stall_cnt = 0`.
- Tag outputs are registered. A decode entry captured at edge N appears on `ex_*` after edge N, on `*_mem` after edge N+1, and on `*_wb` after edge N+2, provided there is no `stall_in`.
- `load_use_stall` is combinational from the EX slot and the decode inputs, with no registered delay.
- `stall_in` and `load_use_stall` asserted together: `stall_in` wins and nothing moves. The stall is re-evaluated on the next cycle.
- `flush_ex` and a load-use match together: `flush_ex` wins and `load_use_stall` is 0.
- `rst_n` deasserted mid-stream: all in-flight tags are lost. No partial state survives.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - `stall_cnt` exists.
  - It increments on every edge where `load_use_stall & ~stall_in`.
  - It saturates at all-ones and does not wrap.
  - It is cleared only by reset.
- `HAZ_PERF_CNT_EN` undefined: the `stall_cnt` port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `hazard_pkg` contains:
  - `REG_AW`.
  - Constant `REG_X0 = 0`.
  - Typedef `tag_entry_t` = `{valid, rd, we, is_load}`.
  - Bubble constant `TAG_BUBBLE`.
- Sub-module `tag_stage`: one slot register with `hold` and `bubble` controls and asynchronous reset to `TAG_BUBBLE`. It is instantiated three times.
- The top level contains only the priority control, the load-use compare, the output gating and the optional counter.

## Test plan
- Reset, then an ALU op with `id_rd = 5`, `id_we = 1`, `id_valid = 1` → `ex_rd = 5` after edge 1, `rd_mem = 5`/`we_mem = 1` after edge 2, `rd_wb = 5`/`we_wb = 1` after edge 3.
- A load to x7 in EX while decode has `id_ra = 7` → `load_use_stall = 1` in the same cycle. Next cycle EX is a bubble and `we_mem = 0` (load in MEM is gated). One cycle later `rd_wb = 7`, `we_wb = 1`. `stall_cnt` = 1 with `HAZ_PERF_CNT_EN`.
- A load to x7 in EX with `id_rb = 7`, `id_uses_rb = 0` → `load_use_stall = 0`.
- `id_rd = 0`, `id_we = 1` → `we` stays 0 in all stages.
- `stall_in = 1` for 3 cycles with a valid entry in EX → all outputs frozen for 3 cycles, then resume advancing. `flush_ex = 1` during a load-use match → `load_use_stall = 0` and EX becomes a bubble.
- `rst_n` pulsed low asynchronously mid-cycle with all three slots valid → all outputs 0 immediately, before the next clock edge.
